// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction-memory read bus between the fetch sequencer and the memory.
//   im_req    : one-cycle read request pulse (fetch unit -> memory)
//   im_addr   : read address, mirrors the fetch unit PC (fetch unit -> memory)
//   im_rdata  : returned instruction word, valid with im_valid (memory -> fetch unit)
//   im_valid  : read data valid, variable latency (memory -> fetch unit)
// Modports: master = fetch unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_rdata;
    logic              im_valid;

    modport master (
        output im_req,
        output im_addr,
        input  im_rdata,
        input  im_valid
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_rdata,
        output im_valid
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch sequencer upstream of the instruction register. A fetch request issues
// the PC to instruction memory, waits for the variable-latency returned word,
// presents it to the IR with a one-cycle write strobe and advances the PC.
// Jumps load the PC while idle; a memory that never answers trips a sticky
// timeout flag.
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   i_fetch     : fetch request, sampled in IDLE only
//   i_jump      : load PC from i_jump_addr, sampled in IDLE only
//   i_jump_addr : jump target
//   im_bus      : instruction-memory bus (master side)
//   o_ir_data   : registered instruction word to the IR input bus
//   o_ir_wr     : IR write strobe, one-cycle pulse
//   o_busy      : high in any state other than IDLE
//   o_done      : one-cycle pulse coincident with o_ir_wr
//   o_err       : sticky timeout flag, cleared by the next accepted fetch
//   o_pc        : current PC
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_fetch,
    input  logic                    i_jump,
    input  logic [ADDR_W-1:0]       i_jump_addr,
    instr_fetch_unit_if.master      im_bus,
    output logic [DATA_W-1:0]       o_ir_data,
    output logic                    o_ir_wr,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic [ADDR_W-1:0]       o_pc
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value seen on the TIMEOUT-th consecutive WAIT cycle.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        LOAD = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir_data;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_im_req;
    logic              r_ir_wr;
    logic              r_done;
    logic              r_busy;
    logic              r_err;

    // Strobes and busy are registered alongside the state transition so each
    // one is high exactly while the FSM sits in the corresponding state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_ir_data  <= '0;
            r_wait_cnt <= '0;
            r_im_req   <= 1'b0;
            r_ir_wr    <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_im_req <= 1'b0;
            r_ir_wr  <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    // The jump target lands in r_pc at the same edge that
                    // enters REQ, so a combined jump+fetch reads jump_addr.
                    if (i_jump) begin
                        r_pc <= i_jump_addr;
                    end
                    if (i_fetch) begin
                        r_state  <= REQ;
                        r_err    <= 1'b0;
                        r_im_req <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                REQ: begin
                    r_wait_cnt <= '0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    // Valid is checked first so it wins on the last WAIT cycle.
                    if (im_bus.im_valid) begin
                        r_ir_data <= im_bus.im_rdata;
                        r_state   <= LOAD;
                        r_ir_wr   <= 1'b1;
                        r_done    <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                        if (r_wait_cnt == LAST_WAIT) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                LOAD: begin
                    r_pc    <= r_pc + ADDR_W'(1);
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign im_bus.im_req  = r_im_req;
    assign im_bus.im_addr = r_pc;
    assign o_ir_data      = r_ir_data;
    assign o_ir_wr        = r_ir_wr;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_pc           = r_pc;

endmodule
